// File: rtl/bus_master_68k_pkg.sv
// Shared types and constants for the 68000-style bus master.
package bus_master_68k_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_OWN,
    ST_S0,
    ST_S2,
    ST_S4,
    ST_S6,
    ST_S7
  } state_t;

  localparam logic [1:0] BE_NONE  = 2'b00;
  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_BOTH  = 2'b11;

  localparam int TIMEOUT_DEFAULT = 64;

  // An empty byte mask is not a legal request; treat it as a full word access.
  function automatic logic [1:0] decode_be(input logic [1:0] be);
    return (be == BE_NONE) ? BE_BOTH : be;
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating 8-bit wait-state counter that flags when the DTACK wait limit is reached.
module bus_timeout_ctr #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (int'(count) >= LIMIT);

endmodule

// File: rtl/bus_master_68k.sv
// 68000 bus master: arbitrates for the bus, then runs S0..S7 read/write cycles
// with DTACK wait states, BERR and an internal timeout.
module bus_master_68k
  import bus_master_68k_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        CLKCPU,
  input  logic        RESET_n,
  input  logic        REQ,
  input  logic        RW,
  input  logic [1:0]  BYTE_EN,
  input  logic [22:0] ADDR,
  input  logic [15:0] WDATA,
  output logic        ACK,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic        BR_n,
  output logic        BGACK_n,
  input  logic        BG_n,
  input  logic        AS_IN_n,
  input  logic        DTACK_n,
  input  logic        BERR_n,
  output logic        AS_n,
  output logic        UDS_n,
  output logic        LDS_n,
  output logic        RW_n,
  output logic [22:0] A_OUT,
  output logic [15:0] D_OUT,
  input  logic [15:0] D_IN,
  output logic        ADDR_OE,
  output logic        DATA_OE
);

  state_t      state;
  state_t      state_next;
  logic [22:0] addr_reg;
  logic [15:0] wdata_reg;
  logic [15:0] rdata_reg;
  logic        rw_reg;
  logic [1:0]  be_reg;
  logic        err_reg;
  logic        expired;
  logic        ctr_clear;
  logic        ctr_enable;
  logic        in_cycle;
  logic        strobe_on;

  assign ctr_clear  = (state == ST_S0);
  assign ctr_enable = (state == ST_S4) && DTACK_n && BERR_n;

  bus_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (CLKCPU),
    .rst_n  (RESET_n),
    .clear  (ctr_clear),
    .enable (ctr_enable),
    .expired(expired)
  );

  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request attributes are captured once on the way into S0 and held for the whole cycle.
  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      addr_reg  <= 23'd0;
      wdata_reg <= 16'd0;
      rdata_reg <= 16'd0;
      rw_reg    <= 1'b1;
      be_reg    <= BE_BOTH;
      err_reg   <= 1'b0;
    end else begin
      if (state == ST_OWN && REQ) begin
        addr_reg  <= ADDR;
        wdata_reg <= WDATA;
        rw_reg    <= RW;
        be_reg    <= decode_be(BYTE_EN);
      end
      if (state == ST_S4) begin
        err_reg <= (state_next == ST_S7);
      end
      if (state == ST_S6 && rw_reg) begin
        rdata_reg <= D_IN;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (REQ) state_next = ST_ARB;
      ST_ARB:  if (!BG_n && AS_IN_n && DTACK_n) state_next = ST_OWN;
      ST_OWN:  state_next = REQ ? ST_S0 : ST_IDLE;
      ST_S0:   state_next = ST_S2;
      ST_S2:   state_next = ST_S4;
      // Bus error takes priority over a coincident DTACK.
      ST_S4: begin
        if (!BERR_n)       state_next = ST_S7;
        else if (!DTACK_n) state_next = ST_S6;
        else if (expired)  state_next = ST_S7;
      end
      ST_S6:   state_next = ST_S7;
      ST_S7:   state_next = ST_OWN;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_cycle  = (state == ST_S0) || (state == ST_S2) || (state == ST_S4) ||
                (state == ST_S6) || (state == ST_S7);
    // Reads open the data strobes in S2, writes wait until data has settled (S4).
    strobe_on = ((state == ST_S2) && rw_reg) || (state == ST_S4) || (state == ST_S6);

    BR_n    = (state != ST_ARB);
    BGACK_n = !((state == ST_OWN) || in_cycle);
    ADDR_OE = in_cycle;
    A_OUT   = addr_reg;
    D_OUT   = wdata_reg;
    RW_n    = (in_cycle && state != ST_S7) ? rw_reg : 1'b1;
    AS_n    = !((state == ST_S2) || (state == ST_S4) || (state == ST_S6));
    UDS_n   = !(strobe_on && ((be_reg & BE_UPPER) != 2'b00));
    LDS_n   = !(strobe_on && ((be_reg & BE_LOWER) != 2'b00));
    DATA_OE = !rw_reg && ((state == ST_S2) || (state == ST_S4) || (state == ST_S6));
    ACK     = (state == ST_S7);
    ERR     = (state == ST_S7) && err_reg;
    RDATA   = rdata_reg;
  end

endmodule

// File: tb/tb_bus_master_68k.sv
// Randomized self-checking bench for bus_master_68k against a cycle-index protocol model.
module tb_bus_master_68k;

  localparam int T = 64;

  logic        CLKCPU  = 1'b0;
  logic        RESET_n = 1'b0;
  logic        REQ     = 1'b0;
  logic        RW      = 1'b1;
  logic [1:0]  BYTE_EN = 2'b11;
  logic [22:0] ADDR    = 23'd0;
  logic [15:0] WDATA   = 16'd0;
  logic        BG_n    = 1'b1;
  logic        AS_IN_n = 1'b1;
  logic        DTACK_n = 1'b1;
  logic        BERR_n  = 1'b1;
  logic [15:0] D_IN    = 16'd0;
  logic        ACK, ERR, BR_n, BGACK_n, AS_n, UDS_n, LDS_n, RW_n, ADDR_OE, DATA_OE;
  logic [15:0] RDATA, D_OUT;
  logic [22:0] A_OUT;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_rdata = 16'd0;

  logic [9:0] ctl;
  logic [7:0] strb;
  assign ctl  = {BR_n, BGACK_n, AS_n, UDS_n, LDS_n, RW_n, ADDR_OE, DATA_OE, ACK, ERR};
  assign strb = {ACK, ERR, AS_n, UDS_n, LDS_n, RW_n, ADDR_OE, DATA_OE};

  localparam logic [9:0] CTL_RESET = 10'b1111110000;

  bus_master_68k #(.TIMEOUT_CYCLES(T)) dut (
    .CLKCPU(CLKCPU), .RESET_n(RESET_n), .REQ(REQ), .RW(RW), .BYTE_EN(BYTE_EN),
    .ADDR(ADDR), .WDATA(WDATA), .ACK(ACK), .ERR(ERR), .RDATA(RDATA),
    .BR_n(BR_n), .BGACK_n(BGACK_n), .BG_n(BG_n), .AS_IN_n(AS_IN_n),
    .DTACK_n(DTACK_n), .BERR_n(BERR_n), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
    .RW_n(RW_n), .A_OUT(A_OUT), .D_OUT(D_OUT), .D_IN(D_IN),
    .ADDR_OE(ADDR_OE), .DATA_OE(DATA_OE)
  );

  always #5 CLKCPU = ~CLKCPU;

  // From IDLE at a falling edge: request, optionally see the bus held busy, end in OWN.
  task automatic acquire(input int busy);
    @(negedge CLKCPU);
    REQ = 1'b1; BG_n = 1'b1; AS_IN_n = 1'b1;
    @(negedge CLKCPU);
    checks++;
    if ({BR_n, BGACK_n} !== 2'b01) begin
      failures++; $display("FAIL arb_request got=%b exp=01", {BR_n, BGACK_n});
    end
    BG_n = 1'b0;
    AS_IN_n = (busy > 0) ? 1'b0 : 1'b1;
    for (int i = 0; i < busy; i++) begin
      @(negedge CLKCPU);
      checks++;
      if ({BR_n, BGACK_n} !== 2'b01) begin
        failures++; $display("FAIL arb_hold wait=%0d got=%b exp=01", i, {BR_n, BGACK_n});
      end
      if (i == busy - 1) AS_IN_n = 1'b1;
    end
    @(negedge CLKCPU);
    checks++;
    if ({BR_n, BGACK_n} !== 2'b10) begin
      failures++; $display("FAIL arb_grant got=%b exp=10", {BR_n, BGACK_n});
    end
    BG_n = 1'b1;
  endtask

  // mode: 0 DTACK after k waits, 1 BERR after k waits, 2 DTACK+BERR together, 3 no response.
  task automatic txn(input logic rw, input logic [1:0] be, input logic [22:0] addr,
                     input logic [15:0] wdata, input int mode, input int k,
                     input logic [15:0] din, input logic keep);
    int          lat;
    logic        errx, ds_on, hit;
    logic [1:0]  bee;
    logic [15:0] final_rd;
    logic [7:0]  exp_v;
    errx     = (mode != 0);
    lat      = (mode == 3) ? 3 + T : ((mode == 0) ? 4 + k : 3 + k);
    bee      = (be == 2'b00) ? 2'b11 : be;
    final_rd = (rw && !errx) ? din : model_rdata;
    RW = rw; BYTE_EN = be; ADDR = addr; WDATA = wdata; REQ = 1'b1;
    for (int c = 0; c <= lat; c++) begin
      @(negedge CLKCPU);
      ds_on = (c < lat) && (c >= (rw ? 1 : 2));
      exp_v = {(c == lat), (c == lat) && errx, !(c >= 1 && c < lat),
               !(ds_on && bee[1]), !(ds_on && bee[0]), (c < lat) ? rw : 1'b1,
               1'b1, !rw && c >= 1 && c < lat};
      checks++;
      if (strb !== exp_v) begin
        failures++; $display("FAIL txn_ctl cycle=%0d got=%b exp=%b", c, strb, exp_v);
      end
      checks++;
      if (A_OUT !== addr) begin
        failures++; $display("FAIL txn_addr cycle=%0d got=%h exp=%h", c, A_OUT, addr);
      end
      if (exp_v[0]) begin
        checks++;
        if (D_OUT !== wdata) begin
          failures++; $display("FAIL txn_dout cycle=%0d got=%h exp=%h", c, D_OUT, wdata);
        end
      end
      checks++;
      if (RDATA !== ((c == lat) ? final_rd : model_rdata)) begin
        failures++;
        $display("FAIL txn_rdata cycle=%0d got=%h exp=%h", c, RDATA,
                 (c == lat) ? final_rd : model_rdata);
      end
      if (c < lat) begin
        hit     = (mode != 3) && (c == 2 + k);
        DTACK_n = !(hit && (mode == 0 || mode == 2));
        BERR_n  = !(hit && mode != 0);
        D_IN    = (mode != 3 && c >= 2 + k) ? din : 16'($urandom);
        REQ     = 1'($urandom);
      end else begin
        DTACK_n = 1'b1; BERR_n = 1'b1; REQ = keep;
      end
    end
    model_rdata = final_rd;
    $display("txn rw=%0d be=%b addr=%h wdata=%h mode=%0d wait=%0d ack_at=%0d rdata=%h",
             rw, be, addr, wdata, mode, k, lat, RDATA);
  endtask

  task automatic own_cycle();
    @(negedge CLKCPU);
    checks++;
    if ({ACK, BGACK_n, ADDR_OE, AS_n} !== 4'b0001) begin
      failures++; $display("FAIL own_cycle got=%b exp=0001", {ACK, BGACK_n, ADDR_OE, AS_n});
    end
  endtask

  task automatic release_bus();
    own_cycle();
    @(negedge CLKCPU);
    checks++;
    if ({BR_n, BGACK_n, ADDR_OE, AS_n, ACK} !== 5'b11010) begin
      failures++;
      $display("FAIL release got=%b exp=11010", {BR_n, BGACK_n, ADDR_OE, AS_n, ACK});
    end
  endtask

  task automatic test_reset();
    RESET_n = 1'b0;
    #13;
    checks++;
    if (ctl !== CTL_RESET) begin
      failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_RESET);
    end
    checks++;
    if (RDATA !== 16'd0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0000", RDATA);
    end
    @(negedge CLKCPU);
    RESET_n = 1'b1;
    repeat (3) begin
      @(negedge CLKCPU);
      checks++;
      if (ctl !== CTL_RESET) begin
        failures++; $display("FAIL reset_quiet got=%b exp=%b", ctl, CTL_RESET);
      end
    end
  endtask

  task automatic test_read_basic();
    acquire(0);
    txn(1'b1, 2'b11, 23'h100000, 16'($urandom), 0, 0, 16'hBEEF, 1'b0);
    release_bus();
  endtask

  task automatic test_write_delayed();
    acquire(0);
    txn(1'b0, 2'b01, 23'($urandom), 16'h12A5, 0, 3, 16'($urandom), 1'b0);
    release_bus();
  endtask

  task automatic test_berr_dtack();
    acquire(0);
    txn(1'b1, 2'b11, 23'($urandom), 16'($urandom), 2, $urandom_range(0, 3), 16'h5555, 1'b0);
    release_bus();
  endtask

  task automatic test_timeout();
    acquire(0);
    txn(1'($urandom), 2'($urandom), 23'($urandom), 16'($urandom), 3, 0, 16'($urandom), 1'b0);
    release_bus();
  endtask

  task automatic test_arbitration();
    acquire($urandom_range(1, 4));
    txn(1'b1, 2'b10, 23'($urandom), 16'($urandom), 0, 1, 16'($urandom), 1'b0);
    release_bus();
  endtask

  task automatic test_back_to_back();
    acquire(0);
    for (int i = 0; i < 4; i++) begin
      txn(1'($urandom), 2'($urandom), 23'($urandom), 16'($urandom), 0,
          $urandom_range(0, 2), 16'($urandom), (i < 3));
      if (i < 3) own_cycle();
    end
    release_bus();
  endtask

  task automatic test_random();
    int n, mode;
    for (int it = 0; it < 15; it++) begin
      acquire($urandom_range(0, 2));
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        mode = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
        txn(1'($urandom), 2'($urandom), 23'($urandom), 16'($urandom), mode,
            $urandom_range(0, 6), 16'($urandom), (j < n - 1));
        if (j < n - 1) own_cycle();
      end
      release_bus();
    end
  endtask

  task automatic test_reset_mid();
    acquire(0);
    RW = 1'b0; BYTE_EN = 2'b11; WDATA = 16'hA5A5; REQ = 1'b1;
    DTACK_n = 1'b1; BERR_n = 1'b1;
    repeat (3) @(negedge CLKCPU);
    checks++;
    if ({AS_n, DATA_OE} !== 2'b01) begin
      failures++; $display("FAIL midreset_setup got=%b exp=01", {AS_n, DATA_OE});
    end
    #2 RESET_n = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_RESET) begin
      failures++; $display("FAIL midreset_ctl got=%b exp=%b", ctl, CTL_RESET);
    end
    checks++;
    if (RDATA !== 16'd0) begin
      failures++; $display("FAIL midreset_rdata got=%h exp=0000", RDATA);
    end
    model_rdata = 16'd0;
    @(negedge CLKCPU);
    RESET_n = 1'b1; REQ = 1'b0;
    repeat (3) begin
      @(negedge CLKCPU);
      checks++;
      if (ctl !== CTL_RESET) begin
        failures++; $display("FAIL midreset_idle got=%b exp=%b", ctl, CTL_RESET);
      end
    end
    $display("txn mid-cycle reset applied and released");
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_delayed();
    test_berr_dtack();
    test_timeout();
    test_arbitration();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
